// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper axis driver: FSM states,
// decoded motion requests and the unipolar half-step coil table.
package stepper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN_POS = 2'd1,
    ST_RUN_NEG = 2'd2,
    ST_DWELL   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MV_STOP = 2'd0,
    MV_POS  = 2'd1,
    MV_NEG  = 2'd2
  } move_e;

  localparam logic [1:0] CMD_MOVE = 2'b01;

  // Element 0 sits in the low nibble: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
  localparam logic [7:0][3:0] HALF_STEP_TABLE = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

  // Conflicting or non-move codes on both lines collapse to STOP.
  function automatic move_e decode_move(input logic [1:0] cmd_pos,
                                        input logic [1:0] cmd_neg);
    logic want_pos;
    logic want_neg;
    want_pos = (cmd_pos == CMD_MOVE);
    want_neg = (cmd_neg == CMD_MOVE);
    if (want_pos && !want_neg) begin
      return MV_POS;
    end else if (want_neg && !want_pos) begin
      return MV_NEG;
    end else begin
      return MV_STOP;
    end
  endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Step-rate prescaler: counts 0..STEP_DIV-1 while enabled and flags the
// terminal count; clr restarts the count so every state starts a fresh period.
module step_tick_gen #(
  parameter int STEP_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = en && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stepper_axis_driver.sv
// Single-axis unipolar stepper driver: decodes direction commands, sequences
// half-steps at a fixed rate and tracks axis position in whole units.
module stepper_axis_driver
  import stepper_pkg::*;
#(
  parameter int STEP_DIV       = 50000,
  parameter int STEPS_PER_UNIT = 11,
  parameter int POS_MAX        = 360,
  parameter int WRAP           = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  cmd_pos,
  input  logic [1:0]  cmd_neg,
  input  logic        pos_load,
  input  logic [15:0] pos_init,
  output logic [3:0]  coil,
  output logic [15:0] pos_actual,
  output logic        step_strobe,
  output logic        busy,
  output logic        at_limit
);

  localparam int SUB_W = (STEPS_PER_UNIT > 1) ? $clog2(STEPS_PER_UNIT) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(STEPS_PER_UNIT - 1);
  localparam logic [15:0] POS_TOP  = 16'(POS_MAX);
  localparam logic [15:0] POS_LAST = 16'(POS_MAX - 1);

  state_e            state_q, state_d;
  logic [2:0]        phase_q, phase_d;
  logic [SUB_W-1:0]  substep_q, substep_d;
  logic [15:0]       pos_q, pos_d;
  logic [3:0]        coil_q, coil_d;
  logic              strobe_q, strobe_d;
  logic              busy_q, busy_d;
  logic              limit_q, limit_d;

  move_e             move;
  logic              tick;
  logic              tick_clr;
  logic              tick_en;
  logic              step_req;
  logic              step_up;
  logic              step_wraps;
  logic              step_blocked;
  logic              run_d;
  logic [15:0]       load_val;

  step_tick_gen #(
    .STEP_DIV (STEP_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .en   (tick_en),
    .tick (tick)
  );

  always_comb begin
    move     = decode_move(cmd_pos, cmd_neg);
    state_d  = state_q;
    step_req = 1'b0;
    step_up  = 1'b0;

    // STOP and reversal take priority over a coinciding terminal tick.
    case (state_q)
      ST_IDLE: begin
        if (move == MV_POS) begin
          state_d = ST_RUN_POS;
        end else if (move == MV_NEG) begin
          state_d = ST_RUN_NEG;
        end
      end
      ST_RUN_POS: begin
        if (move == MV_STOP) begin
          state_d = ST_IDLE;
        end else if (move == MV_NEG) begin
          state_d = ST_DWELL;
        end else if (tick) begin
          step_req = 1'b1;
          step_up  = 1'b1;
        end
      end
      ST_RUN_NEG: begin
        if (move == MV_STOP) begin
          state_d = ST_IDLE;
        end else if (move == MV_POS) begin
          state_d = ST_DWELL;
        end else if (tick) begin
          step_req = 1'b1;
        end
      end
      ST_DWELL: begin
        if (tick) begin
          case (move)
            MV_POS:  state_d = ST_RUN_POS;
            MV_NEG:  state_d = ST_RUN_NEG;
            default: state_d = ST_IDLE;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (WRAP != 0) begin
      load_val = (pos_init >= POS_TOP) ? POS_LAST : pos_init;
    end else begin
      load_val = (pos_init > POS_TOP) ? POS_TOP : pos_init;
    end

    // A step only moves the position when the substep counter wraps, so that
    // is the only kind of step a saturating end stop can refuse.
    step_wraps   = step_up ? (substep_q == SUB_LAST) : (substep_q == '0);
    step_blocked = (WRAP == 0) && step_wraps &&
                   (step_up ? (pos_q == POS_TOP) : (pos_q == '0));

    phase_d   = phase_q;
    substep_d = substep_q;
    pos_d     = pos_q;
    strobe_d  = 1'b0;
    limit_d   = limit_q;

    if (pos_load) begin
      pos_d     = load_val;
      substep_d = '0;
    end else if (step_req) begin
      if (step_blocked) begin
        limit_d = 1'b1;
      end else begin
        limit_d  = 1'b0;
        strobe_d = 1'b1;
        if (step_up) begin
          phase_d   = phase_q + 3'd1;
          substep_d = step_wraps ? '0 : substep_q + SUB_W'(1);
          if (step_wraps) begin
            pos_d = ((WRAP != 0) && (pos_q == POS_LAST)) ? '0 : pos_q + 16'd1;
          end
        end else begin
          phase_d   = phase_q - 3'd1;
          substep_d = step_wraps ? SUB_LAST : substep_q - SUB_W'(1);
          if (step_wraps) begin
            pos_d = ((WRAP != 0) && (pos_q == '0)) ? POS_LAST : pos_q - 16'd1;
          end
        end
      end
    end

    run_d = (state_d == ST_RUN_POS) || (state_d == ST_RUN_NEG);
    if (!run_d || (state_d != state_q)) begin
      limit_d = 1'b0;
    end

    coil_d   = run_d ? HALF_STEP_TABLE[phase_d] : 4'b0000;
    busy_d   = (state_d != ST_IDLE);
    tick_clr = (state_d != state_q);
    tick_en  = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= 3'd0;
      substep_q <= '0;
      pos_q     <= 16'd0;
      coil_q    <= 4'b0000;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      limit_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      substep_q <= substep_d;
      pos_q     <= pos_d;
      coil_q    <= coil_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
      limit_q   <= limit_d;
    end
  end

  assign coil        = coil_q;
  assign pos_actual  = pos_q;
  assign step_strobe = strobe_q;
  assign busy        = busy_q;
  assign at_limit    = limit_q;

endmodule

// File: tb/tb_stepper_axis_driver.sv
// Bench for stepper_axis_driver: a modulo and a saturating axis share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_stepper_axis_driver;

  localparam int SD   = 4;
  localparam int SPU  = 2;
  localparam int PMAX = 360;

  localparam int IDLE_M  = 0;
  localparam int POS_M   = 1;
  localparam int NEG_M   = 2;
  localparam int DWELL_M = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cmdPos;
  logic [1:0]  cmdNeg;
  logic        posLoad;
  logic [15:0] posInit;

  logic [3:0]  coilW, coilS;
  logic [15:0] posW, posS;
  logic        strobeW, strobeS;
  logic        busyW, busyS;
  logic        limitW, limitS;

  int checksTotal  = 0;
  int checksPassed = 0;
  bit checkEn      = 1'b0;

  // Model state, index 0 = modulo axis, index 1 = saturating axis.
  // Position is kept as an absolute half-step count: pos = total / SPU.
  int mMode   [2] = '{0, 0};
  int mAge    [2] = '{0, 0};
  int mPhase  [2] = '{0, 0};
  int mTotal  [2] = '{0, 0};
  bit mStrobe [2] = '{1'b0, 1'b0};
  bit mLimit  [2] = '{1'b0, 1'b0};

  logic [3:0] halfStep [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                               4'b0010, 4'b0011, 4'b0001, 4'b1001};

  always #5 clk = ~clk;

  stepper_axis_driver #(
    .STEP_DIV(SD), .STEPS_PER_UNIT(SPU), .POS_MAX(PMAX), .WRAP(1)
  ) dutWrap (
    .clk(clk), .rst(rst), .cmd_pos(cmdPos), .cmd_neg(cmdNeg),
    .pos_load(posLoad), .pos_init(posInit), .coil(coilW),
    .pos_actual(posW), .step_strobe(strobeW), .busy(busyW), .at_limit(limitW)
  );

  stepper_axis_driver #(
    .STEP_DIV(SD), .STEPS_PER_UNIT(SPU), .POS_MAX(PMAX), .WRAP(0)
  ) dutSat (
    .clk(clk), .rst(rst), .cmd_pos(cmdPos), .cmd_neg(cmdNeg),
    .pos_load(posLoad), .pos_init(posInit), .coil(coilS),
    .pos_actual(posS), .step_strobe(strobeS), .busy(busyS), .at_limit(limitS)
  );

  // 0 = stop, 1 = move positive, 2 = move negative
  function automatic int decodeCmd(input logic [1:0] p, input logic [1:0] n);
    if (p == 2'b01 && n != 2'b01) return POS_M;
    if (n == 2'b01 && p != 2'b01) return NEG_M;
    return IDLE_M;
  endfunction

  function automatic logic [3:0] expCoil(input int k);
    return (mMode[k] == POS_M || mMode[k] == NEG_M) ? halfStep[mPhase[k]] : 4'b0000;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mMode[k] = IDLE_M; mAge[k] = 0; mPhase[k] = 0; mTotal[k] = 0;
      mStrobe[k] = 1'b0; mLimit[k] = 1'b0;
    end
  endtask

  task automatic modelEdge();
    int cmd;
    cmd = decodeCmd(cmdPos, cmdNeg);
    for (int k = 0; k < 2; k++) begin
      int newMode;
      int dir;
      int nt;
      int span;
      int lv;
      bit attempt;
      newMode = mMode[k];
      attempt = 1'b0;
      mStrobe[k] = 1'b0;
      if (mMode[k] == IDLE_M) begin
        newMode = cmd;
      end else if (mMode[k] == DWELL_M) begin
        if (mAge[k] + 1 == SD) newMode = cmd;
      end else if (cmd != mMode[k]) begin
        newMode = (cmd == IDLE_M) ? IDLE_M : DWELL_M;
      end else begin
        attempt = ((mAge[k] + 1) % SD) == 0;
      end

      if (posLoad) begin
        lv = int'(posInit);
        if (k == 0) lv = (lv >= PMAX) ? PMAX - 1 : lv;
        else        lv = (lv > PMAX) ? PMAX : lv;
        mTotal[k] = lv * SPU;
      end else if (attempt) begin
        dir  = (mMode[k] == POS_M) ? 1 : -1;
        nt   = mTotal[k] + dir;
        span = PMAX * SPU;
        if (k == 0) nt = (nt + span) % span;
        if (k == 1 && (nt < 0 || nt > (PMAX + 1) * SPU - 1)) begin
          mLimit[k] = 1'b1;
        end else begin
          mTotal[k]  = nt;
          mPhase[k]  = (mPhase[k] + dir + 8) % 8;
          mStrobe[k] = 1'b1;
          mLimit[k]  = 1'b0;
        end
      end

      if (newMode != mMode[k]) begin
        mAge[k]   = 0;
        mLimit[k] = 1'b0;
      end else begin
        mAge[k] = mAge[k] + 1;
      end
      mMode[k] = newMode;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) modelReset();
    else     modelEdge();
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, actual, expected);
    end
  endtask

  // Outputs are packed as {coil, pos, strobe, busy, at_limit}.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("wrapAxisCycle", 32'({coilW, posW, strobeW, busyW, limitW}),
                  32'({expCoil(0), 16'(mTotal[0] / SPU), mStrobe[0], mMode[0] != IDLE_M, mLimit[0]}));
      checkOutput("satAxisCycle", 32'({coilS, posS, strobeS, busyS, limitS}),
                  32'({expCoil(1), 16'(mTotal[1] / SPU), mStrobe[1], mMode[1] != IDLE_M, mLimit[1]}));
    end
  end

  task automatic applyStimulus(input logic [1:0] p, input logic [1:0] n,
                               input logic ld, input logic [15:0] init);
    cmdPos  = p;
    cmdNeg  = n;
    posLoad = ld;
    posInit = init;
  endtask

  // Advance n clock edges, sampling 1 time unit after each, counting strobes.
  task automatic runCycles(input int n, output int sw, output int ss);
    sw = 0;
    ss = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (strobeW) sw++;
      if (strobeS) ss++;
    end
  endtask

  initial begin
    int sw, ss, sw2, ss2;
    int zeroCoil, firstStrobe;
    int holdLeft;
    int r;

    rst = 1'b1;
    applyStimulus(2'b00, 2'b00, 1'b0, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    checkEn = 1'b1;
    checkOutput("resetWrap", 32'({coilW, posW, strobeW, busyW, limitW}), 32'd0);
    checkOutput("resetSat", 32'({coilS, posS, strobeS, busyS, limitS}), 32'd0);

    // Continuous positive motion from reset: 10 half-steps -> phase 2, unit 5.
    rst = 1'b0;
    applyStimulus(2'b01, 2'b00, 1'b0, 16'd0);
    runCycles(5, sw, ss);
    checkOutput("firstStepStrobes", 32'(sw), 32'd1);
    checkOutput("firstStepCoil", 32'(coilW), 32'(4'b1100));
    runCycles(36, sw2, ss2);
    checkOutput("tenStepStrobes", 32'(sw + sw2), 32'd10);
    checkOutput("tenStepCoil", 32'(coilW), 32'(4'b0100));
    checkOutput("tenStepPosWrap", 32'(posW), 32'd5);
    checkOutput("tenStepPosSat", 32'(posS), 32'd5);
    applyStimulus(2'b00, 2'b00, 1'b0, 16'd0);
    runCycles(2, sw, ss);

    // Homing load to 359, then wrap across zero and back on the modulo axis.
    applyStimulus(2'b00, 2'b00, 1'b1, 16'd359);
    runCycles(1, sw, ss);
    checkOutput("loadPos", 32'(posW), 32'd359);
    applyStimulus(2'b01, 2'b00, 1'b0, 16'd0);
    runCycles(9, sw, ss);
    checkOutput("wrapUpPos", 32'(posW), 32'd0);
    checkOutput("satUpPos", 32'(posS), 32'd360);
    applyStimulus(2'b00, 2'b01, 1'b0, 16'd0);
    runCycles(13, sw, ss);
    checkOutput("wrapDownPos", 32'(posW), 32'd359);
    applyStimulus(2'b00, 2'b00, 1'b0, 16'd0);
    runCycles(2, sw, ss);

    // Saturating axis parked at 0 refuses negative steps.
    applyStimulus(2'b00, 2'b00, 1'b1, 16'd0);
    runCycles(1, sw, ss);
    applyStimulus(2'b00, 2'b01, 1'b0, 16'd0);
    runCycles(13, sw, ss);
    checkOutput("limitNoStrobe", 32'(ss), 32'd0);
    checkOutput("limitFlag", 32'(limitS), 32'd1);
    checkOutput("limitCoilFrozen", 32'(coilS), 32'(4'b0100));
    applyStimulus(2'b01, 2'b00, 1'b0, 16'd0);
    runCycles(1, sw, ss);
    checkOutput("limitClears", 32'(limitS), 32'd0);
    runCycles(8, sw, ss);
    checkOutput("limitResumeStrobes", 32'(ss), 32'd1);
    applyStimulus(2'b00, 2'b00, 1'b0, 16'd0);
    runCycles(2, sw, ss);

    // Reversal two cycles into a step period: DWELL on edge 1, RUN_NEG on 5, strobe on 9.
    applyStimulus(2'b01, 2'b00, 1'b0, 16'd0);
    runCycles(7, sw, ss);
    applyStimulus(2'b00, 2'b01, 1'b0, 16'd0);
    zeroCoil = 0;
    firstStrobe = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (e <= 8 && coilW == 4'b0000) zeroCoil++;
      if (strobeW && firstStrobe < 0) firstStrobe = e;
    end
    checkOutput("dwellZeroCoil", 32'(zeroCoil), 32'd4);
    checkOutput("dwellFirstStrobe", 32'(firstStrobe), 32'd9);
    applyStimulus(2'b00, 2'b00, 1'b0, 16'd0);
    runCycles(2, sw, ss);

    // Conflicting and non-move codes keep both axes idle.
    applyStimulus(2'b01, 2'b01, 1'b0, 16'd0);
    runCycles(3, sw, ss);
    checkOutput("bothMoveIdle", 32'({busyW, coilW, busyS, coilS}), 32'd0);
    applyStimulus(2'b11, 2'b00, 1'b0, 16'd0);
    runCycles(3, sw, ss);
    checkOutput("code11Idle", 32'({busyW, coilW, busyS, coilS}), 32'd0);

    // Reset one edge before a step is due aborts it; restart begins at phase 0.
    applyStimulus(2'b01, 2'b00, 1'b0, 16'd0);
    runCycles(4, sw, ss);
    rst = 1'b1;
    #1;
    checkOutput("midStepReset", 32'({coilW, posW, strobeW, busyW, limitW}), 32'd0);
    runCycles(1, sw, ss);
    checkOutput("midStepNoStrobe", 32'(sw + ss), 32'd0);
    rst = 1'b0;
    runCycles(1, sw, ss);
    checkOutput("restartCoil", 32'(coilW), 32'(4'b1000));
    runCycles(4, sw, ss);
    checkOutput("restartStep", 32'({coilW, 4'(sw)}), 32'({4'b1100, 4'd1}));
    applyStimulus(2'b00, 2'b00, 1'b0, 16'd0);
    runCycles(2, sw, ss);

    // Randomized traffic: held commands, homing loads near the ends, rare resets.
    holdLeft = 0;
    for (int c = 0; c < 1500; c++) begin
      posLoad = 1'b0;
      if (holdLeft == 0) begin
        r = int'($urandom_range(0, 9));
        if (r <= 3)      applyStimulus(2'b01, 2'(r == 0 ? 2 : 0), 1'b0, posInit);
        else if (r <= 6) applyStimulus(2'(r == 4 ? 3 : 0), 2'b01, 1'b0, posInit);
        else if (r == 7) applyStimulus(2'b01, 2'b01, 1'b0, posInit);
        else if (r == 8) applyStimulus(2'b11, 2'($urandom_range(0, 3)), 1'b0, posInit);
        else             applyStimulus(2'b00, 2'b00, 1'b0, posInit);
        holdLeft = int'($urandom_range(1, 30));
      end
      holdLeft--;
      if ($urandom_range(0, 39) == 0) begin
        posLoad = 1'b1;
        case ($urandom_range(0, 6))
          0: posInit = 16'd0;
          1: posInit = 16'd1;
          2: posInit = 16'd359;
          3: posInit = 16'd360;
          4: posInit = 16'd361;
          5: posInit = 16'hFFFF;
          default: posInit = 16'($urandom_range(0, 400));
        endcase
      end
      rst = ($urandom_range(0, 299) == 0);
      runCycles(1, sw, ss);
    end
    rst = 1'b0;
    posLoad = 1'b0;
    runCycles(2, sw, ss);

    checkEn = 1'b0;
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
